// File: rtl/pong_pkg.sv
// pong_pkg: shared field geometry, object sizes, score glyph layout, colour classes and flash FSM states.
package pong_pkg;
    localparam logic [9:0] FIELD_X_BEGIN = 10'd8;
    localparam logic [9:0] FIELD_X_END   = 10'd631;
    localparam logic [9:0] FIELD_Y_BEGIN = 10'd8;
    localparam logic [9:0] FIELD_Y_END   = 10'd471;

    localparam logic signed [10:0] BALL_RADIUS      = 11'sd4;
    localparam logic signed [10:0] PADDLE_RADIUS    = 11'sd24;
    localparam logic        [10:0] PADDLE_THICKNESS = 11'd8;

    localparam logic signed [10:0] SCORE_L_X   = 11'sd280;
    localparam logic signed [10:0] SCORE_R_X   = 11'sd340;
    localparam logic signed [10:0] SCORE_Y     = 11'sd16;
    localparam logic signed [10:0] SCORE_W     = 11'sd12;
    localparam logic signed [10:0] SCORE_H     = 11'sd20;
    localparam logic signed [10:0] SCORE_SEG_T = 11'sd2;

    typedef enum logic [1:0] {COL_BG, COL_BORDER, COL_WHITE} colour_t;
    typedef enum logic {IDLE, FLASH} flash_state_t;

    // Segment order {a,b,c,d,e,f,g}; anything above 9 is blank.
    function automatic logic [6:0] seg7_mask(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction
endpackage

// File: rtl/pong_pixel_pipeline_if.sv
// pong_pixel_pipeline_if: raster, game-state and colour signals of the pong pixel pipeline.
interface pong_pixel_pipeline_if #(
    parameter int NUM_PADDLES = 2,
    parameter int R_W         = 3,
    parameter int G_W         = 3,
    parameter int B_W         = 2
);
    logic [9:0]               pix_x, pix_y;
    logic                     pix_valid, frame_start;
    logic [9:0]               ball_x, ball_y;
    logic [10*NUM_PADDLES-1:0] paddle_x, paddle_y;
    logic [3:0]               left_score, right_score;
    logic [R_W-1:0]           r;
    logic [G_W-1:0]           g;
    logic [B_W-1:0]           b;
    logic                     rgb_valid;

    modport master (
        output pix_x, pix_y, pix_valid, frame_start, ball_x, ball_y,
               paddle_x, paddle_y, left_score, right_score,
        input  r, g, b, rgb_valid
    );
    modport slave (
        input  pix_x, pix_y, pix_valid, frame_start, ball_x, ball_y,
               paddle_x, paddle_y, left_score, right_score,
        output r, g, b, rgb_valid
    );
endinterface

// File: rtl/seg7_glyph.sv
// seg7_glyph: combinational 7-segment digit hit test at box-local coordinates.
module seg7_glyph
    import pong_pkg::*;
(
    input  logic [3:0]         digit,
    input  logic signed [10:0] x,
    input  logic signed [10:0] y,
    output logic               hit
);
    logic in_box, left, right, upper;
    logic [6:0] seg;
    assign in_box = !x[10] && !y[10] && x < SCORE_W && y < SCORE_H;
    assign left   = x < SCORE_SEG_T;
    assign right  = x >= SCORE_W - SCORE_SEG_T;
    assign upper  = y < (SCORE_H >>> 1);
    assign seg = {y < SCORE_SEG_T, right && upper, right && !upper, y >= SCORE_H - SCORE_SEG_T,
                  left && !upper, left && upper,
                  y >= (SCORE_H >>> 1) - 11'sd1 && y <= (SCORE_H >>> 1)};
    assign hit = in_box && |(seg & seg7_mask(digit));
endmodule

// File: rtl/pong_pixel_pipeline.sv
// pong_pixel_pipeline: 2-stage pong renderer with per-frame snapshots and a score-change border flash.
// Define PONG_SCORE_DISPLAY_EN to draw the scores as 7-segment digits; otherwise the digits stay blank.
module pong_pixel_pipeline
    import pong_pkg::*;
#(
    parameter int NUM_PADDLES  = 2,
    parameter int R_W          = 3,
    parameter int G_W          = 3,
    parameter int B_W          = 2,
    parameter int FLASH_FRAMES = 30
) (
    input logic clk,
    input logic reset,
    pong_pixel_pipeline_if.slave bus
);
    localparam logic [G_W-1:0] BORDER_G = G_W'(1) << (G_W - 1);
    localparam logic [B_W-1:0] BORDER_B = B_W'(1);

    logic [9:0] ball_xs, ball_ys;
    logic [10*NUM_PADDLES-1:0] pad_xs, pad_ys;
    logic [3:0] left_s, right_s, left_d, right_d;
    logic score_change;
    assign score_change = {bus.left_score, bus.right_score} != {left_s, right_s};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ball_xs <= '0;
            ball_ys <= '0;
            pad_xs  <= '0;
            pad_ys  <= '0;
            left_s  <= '0;
            right_s <= '0;
        end else if (bus.frame_start) begin
            ball_xs <= bus.ball_x;
            ball_ys <= bus.ball_y;
            pad_xs  <= bus.paddle_x;
            pad_ys  <= bus.paddle_y;
            left_s  <= bus.left_score;
            right_s <= bus.right_score;
        end

    flash_state_t state, state_n;
    logic [7:0] cnt, cnt_n;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (bus.frame_start && score_change) begin
            state_n = FLASH;
            cnt_n   = 8'(FLASH_FRAMES);
        end else if (bus.frame_start && state == FLASH) begin
            cnt_n   = cnt - 8'd1;
            state_n = cnt == 8'd1 ? IDLE : FLASH;
        end
    end

    // Hit tests run in 11-bit signed space so centres near 0 never wrap.
    logic signed [10:0] ball_dx, ball_dy, sl_x, sr_x, s_y;
    logic [NUM_PADDLES-1:0] pad_hit, pad_q;
    logic ball_hit, border_hit, score_hit, left_hit, right_hit;
    logic valid_q, ball_q, border_q, score_q;

    assign ball_dx  = signed'({1'b0, bus.pix_x}) - signed'({1'b0, ball_xs});
    assign ball_dy  = signed'({1'b0, bus.pix_y}) - signed'({1'b0, ball_ys});
    assign ball_hit = ball_dx >= -BALL_RADIUS && ball_dx <= BALL_RADIUS &&
                      ball_dy >= -BALL_RADIUS && ball_dy <= BALL_RADIUS;

    for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_pad
        logic [10:0] px;
        logic signed [10:0] dy;
        assign px = {1'b0, pad_xs[10*i +: 10]};
        assign dy = signed'({1'b0, bus.pix_y}) - signed'({1'b0, pad_ys[10*i +: 10]});
        assign pad_hit[i] = {1'b0, bus.pix_x} >= px && {1'b0, bus.pix_x} <= px + PADDLE_THICKNESS &&
                            dy >= -PADDLE_RADIUS && dy <= PADDLE_RADIUS;
    end

    assign border_hit = bus.pix_x < FIELD_X_BEGIN || bus.pix_x > FIELD_X_END ||
                        bus.pix_y < FIELD_Y_BEGIN || bus.pix_y > FIELD_Y_END;

`ifdef PONG_SCORE_DISPLAY_EN
    assign left_d  = left_s;
    assign right_d = right_s;
`else
    assign left_d  = 4'hf;
    assign right_d = 4'hf;
`endif

    assign sl_x = signed'({1'b0, bus.pix_x}) - SCORE_L_X;
    assign sr_x = signed'({1'b0, bus.pix_x}) - SCORE_R_X;
    assign s_y  = signed'({1'b0, bus.pix_y}) - SCORE_Y;

    seg7_glyph u_left  (.digit(left_d),  .x(sl_x), .y(s_y), .hit(left_hit));
    seg7_glyph u_right (.digit(right_d), .x(sr_x), .y(s_y), .hit(right_hit));
    assign score_hit = left_hit || right_hit;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            valid_q  <= 1'b0;
            ball_q   <= 1'b0;
            pad_q    <= '0;
            border_q <= 1'b0;
            score_q  <= 1'b0;
        end else begin
            valid_q  <= bus.pix_valid;
            ball_q   <= ball_hit;
            pad_q    <= pad_hit;
            border_q <= border_hit;
            score_q  <= score_hit;
        end

    colour_t col;
    logic flash_white;
    assign flash_white = state == FLASH && cnt[0];
    assign col = !valid_q ? COL_BG :
                 (ball_q || |pad_q || score_q) ? COL_WHITE :
                 !border_q ? COL_BG :
                 flash_white ? COL_WHITE : COL_BORDER;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.rgb_valid <= 1'b0;
            bus.r <= '0;
            bus.g <= '0;
            bus.b <= '0;
        end else begin
            bus.rgb_valid <= valid_q;
            bus.r <= {R_W{col == COL_WHITE}};
            bus.g <= col == COL_WHITE ? {G_W{1'b1}} : col == COL_BORDER ? BORDER_G : '0;
            bus.b <= col == COL_WHITE ? {B_W{1'b1}} : col == COL_BORDER ? BORDER_B : '0;
        end
endmodule

// File: tb/tb_pong_pixel_pipeline.sv
// tb_pong_pixel_pipeline: directed checks of the pong renderer with 4 paddles and a 4-frame flash.
module tb_pong_pixel_pipeline;
    import pong_pkg::*;

    // {rgb_valid, r[2:0], g[2:0], b[1:0]}
    localparam logic [8:0] WHITE = 9'h1ff;
    localparam logic [8:0] TEAL  = 9'h111;
    localparam logic [8:0] BG    = 9'h100;
    localparam logic [8:0] OFF   = 9'h000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    pong_pixel_pipeline_if #(.NUM_PADDLES(4)) bus ();
    pong_pixel_pipeline #(.NUM_PADDLES(4), .FLASH_FRAMES(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {23'd0, bus.rgb_valid, bus.r, bus.g, bus.b};
    endfunction

    task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic v,
                         input logic [8:0] exp, input string tag);
        @(negedge clk);
        bus.pix_x = x;
        bus.pix_y = y;
        bus.pix_valid = v;
        repeat (2) @(posedge clk);
        #1 chk(tag, rgb(), {23'd0, exp});
        bus.pix_valid = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic paddle(input int i, input logic [9:0] x, input logic [9:0] y);
        bus.paddle_x[10*i +: 10] = x;
        bus.paddle_y[10*i +: 10] = y;
    endtask

    initial begin
        bus.pix_x = '0; bus.pix_y = '0; bus.pix_valid = 1'b0; bus.frame_start = 1'b0;
        bus.ball_x = '0; bus.ball_y = '0; bus.paddle_x = '0; bus.paddle_y = '0;
        bus.left_score = '0; bus.right_score = '0;
        repeat (2) @(negedge clk);
        chk("reset_rgb", rgb(), 32'd0);
        chk("reset_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;

        bus.ball_x = 320; bus.ball_y = 240;
        paddle(0, 20, 240); paddle(1, 610, 240); paddle(2, 100, 100); paddle(3, 500, 400);
        frame();

        @(negedge clk);
        bus.pix_x = 323; bus.pix_y = 240; bus.pix_valid = 1'b1;
        @(posedge clk);
        #1 chk("latency_1cyc", rgb(), {23'd0, OFF});
        @(posedge clk);
        #1 chk("latency_2cyc", rgb(), {23'd0, WHITE});
        bus.pix_valid = 1'b0;

        pixel(324, 240, 1, WHITE, "ball_edge_x");
        pixel(325, 240, 1, BG,    "ball_out_x");
        pixel(320, 244, 1, WHITE, "ball_edge_y");
        pixel(320, 245, 1, BG,    "ball_out_y");
        pixel(320, 240, 0, OFF,   "ball_invalid");
        pixel(3,   240, 1, TEAL,  "border_left");
        pixel(320, 475, 1, TEAL,  "border_bottom");
        pixel(631, 240, 1, BG,    "field_x_end");
        pixel(632, 240, 1, TEAL,  "border_right");
        pixel(108, 124, 1, WHITE, "paddle_corner");
        pixel(109, 100, 1, BG,    "paddle_out_x");
        pixel(100, 76,  1, WHITE, "paddle_top");
        pixel(100, 75,  1, BG,    "paddle_out_y");

        bus.ball_x = 2; bus.ball_y = 100;
        frame();
        pixel(1020, 100, 1, TEAL,  "no_wrap_1020");
        pixel(0,    100, 1, WHITE, "ball_at_0");
        pixel(6,    100, 1, WHITE, "ball_at_6");
        pixel(7,    100, 1, TEAL,  "ball_out_7");

        bus.ball_x = 320;
        pixel(0,   100, 1, WHITE, "hold_old_ball");
        pixel(320, 100, 1, BG,    "hold_no_new_ball");
        frame();
        pixel(0,   100, 1, TEAL,  "new_snap_old_pos");
        pixel(320, 100, 1, WHITE, "new_snap_new_pos");

        @(negedge clk);
        bus.ball_x = 500; bus.pix_x = 320; bus.pix_y = 100; bus.pix_valid = 1'b1; bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
        @(posedge clk);
        #1 chk("fs_pixel_old_snap", rgb(), {23'd0, WHITE});
        pixel(320, 100, 1, BG,    "fs_latched_old_gone");
        pixel(500, 100, 1, WHITE, "fs_latched_new");

        paddle(0, 0, 240); paddle(3, 496, 100);
        frame();
        pixel(500, 100, 1, WHITE, "paddle_ball_overlap");
        pixel(504, 120, 1, WHITE, "paddle3_only");
        pixel(4,   240, 1, WHITE, "paddle_over_border");
        pixel(4,   270, 1, TEAL,  "border_below_paddle");
        pixel(4,   240, 0, OFF,   "paddle_invalid");

        bus.left_score = 1;
        frame();
        chk("flash_enter", 32'(dut.state), 32'(FLASH));
        chk("flash_load", 32'(dut.cnt), 32'd4);
        pixel(3, 300, 1, TEAL, "flash_cnt4");
        for (int k = 3; k >= 0; k--) begin
            frame();
            pixel(3, 300, 1, (k % 2) ? WHITE : TEAL, $sformatf("flash_cnt%0d", k));
        end
        chk("flash_done", 32'(dut.state), 32'(IDLE));

        bus.left_score = 2;
        frame();
        frame();
        chk("flash_cnt_dec", 32'(dut.cnt), 32'd3);
        bus.right_score = 1;
        frame();
        chk("flash_reload", 32'(dut.cnt), 32'd4);
        frame();
        pixel(3, 300, 1, WHITE, "flash_after_reload");

        @(negedge clk);
        bus.pix_x = 500; bus.pix_y = 100; bus.pix_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("pre_reset_white", rgb(), {23'd0, WHITE});
        #2 reset = 1'b1;
        #1 chk("reset_rgb_async", rgb(), 32'd0);
        chk("reset_fsm_idle", 32'(dut.state), 32'(IDLE));
        chk("reset_cnt", 32'(dut.cnt), 32'd0);
        chk("reset_snap_ball", 32'(dut.ball_xs), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pixel(500, 100, 1, BG,   "post_reset_zero_snap");
        pixel(3,   300, 1, TEAL, "post_reset_no_flash");
        frame();
        chk("post_reset_flash", 32'(dut.state), 32'(FLASH));
        pixel(500, 100, 1, WHITE, "post_reset_new_snap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
